// File: rtl/pma_pkg.sv
// Shared types for the programmable physical-memory-attribute table.
// Latency: n/a (types only).
// Backpressure: n/a.
package pma_pkg;

    // Storage width of base/len fields; the table's ADDR_W must not exceed it.
    localparam int unsigned PMA_ADDR_W = 64;

    // Bit 0 cached, bit 1 idempotent, bit 2 executable.
    typedef struct packed {
        logic executable;
        logic idempotent;
        logic cached;
    } pma_attr_t;

    typedef enum logic [1:0] {
        FLD_BASE = 2'd0,
        FLD_LEN  = 2'd1,
        FLD_ATTR = 2'd2,
        FLD_LOCK = 2'd3
    } pma_field_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } pma_state_e;

    typedef struct packed {
        logic [PMA_ADDR_W-1:0] base;
        logic [PMA_ADDR_W-1:0] len;
        pma_attr_t             attr;
        logic                  lock;
    } pma_rule_t;

endpackage

// File: rtl/pma_rule_match.sv
// Single-rule address comparator: addr in [base, base+len), len==0 disables.
// Latency: combinational.
// Backpressure: none.
// Ports: addr/base/len in (ADDR_W), match out.
module pma_rule_match
    import pma_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic              match
);

    // Offset is computed modulo 2^ADDR_W; a region ending exactly at the top
    // of the address space therefore needs no extra carry bit.
    logic [ADDR_W-1:0] offset;

    assign offset = addr - base;
    assign match  = (len != '0) && (addr >= base) && (offset < len);

endmodule

// File: rtl/pma_rule_table.sv
// Runtime-programmable PMA table: shadow bank writes, FSM-sequenced atomic commit to active bank.
// Latency: lookup result registered, 1 cycle after handshake; commit done 2 cycles after request.
// Backpressure: lkp_ready_o low while a commit is requested or in progress; responses cannot stall.
// Ports: lkp_* lookup request, rsp_* registered result, cfg_* shadow writes/commit, multi_hit_o sticky flag.
// Optional: define PMA_RULE_TABLE_MULTI_HIT_EN to enable multi_hit_o (otherwise tied 0).
module pma_rule_table
    import pma_pkg::*;
#(
    parameter int unsigned NR_RULES = 8,
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned ATTR_W   = 3,
    parameter logic [ATTR_W-1:0]          DEFAULT_ATTR = 3'b010,
    parameter logic [NR_RULES*ADDR_W-1:0] RST_BASE     = '0,
    parameter logic [NR_RULES*ADDR_W-1:0] RST_LEN      = '0,
    parameter logic [NR_RULES*ATTR_W-1:0] RST_ATTR     = '0,
    localparam int unsigned IDX_W = (NR_RULES > 1) ? $clog2(NR_RULES) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lkp_valid_i,
    output logic              lkp_ready_o,
    input  logic [ADDR_W-1:0] lkp_addr_i,
    output logic              rsp_valid_o,
    output logic [ATTR_W-1:0] rsp_attr_o,
    output logic              rsp_hit_o,
    output logic [IDX_W-1:0]  rsp_idx_o,
    input  logic              cfg_we_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic [1:0]        cfg_sel_i,
    input  logic [ADDR_W-1:0] cfg_wdata_i,
    input  logic              cfg_commit_i,
    output logic              cfg_commit_done_o,
    output logic              cfg_busy_o,
    output logic              multi_hit_o
);

    pma_rule_t  shadow [NR_RULES];
    pma_rule_t  active [NR_RULES];
    pma_state_e state_q, state_d;

    logic [NR_RULES-1:0] match;
    logic                lkp_fire;
    logic                win_hit;
    logic [IDX_W-1:0]    win_idx;
    logic [ATTR_W-1:0]   win_attr;

    logic                rsp_valid_q;
    logic                rsp_hit_q;
    logic [IDX_W-1:0]    rsp_idx_q;
    logic [ATTR_W-1:0]   rsp_attr_q;

    function automatic pma_rule_t rst_rule(input int unsigned i);
        pma_rule_t r;
        r.base = PMA_ADDR_W'(RST_BASE[i*ADDR_W +: ADDR_W]);
        r.len  = PMA_ADDR_W'(RST_LEN[i*ADDR_W +: ADDR_W]);
        r.attr = pma_attr_t'(RST_ATTR[i*ATTR_W +: ATTR_W]);
        r.lock = 1'b0;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Commit sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        cfg_busy_o        = (state_q != IDLE);
        cfg_commit_done_o = 1'b0;
        // A commit request blocks acceptance in the same cycle so that no
        // lookup can straddle the bank swap.
        lkp_ready_o       = (state_q == IDLE) && !cfg_commit_i;
        case (state_q)
            IDLE: begin
                if (cfg_commit_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!rsp_valid_q) state_d = COMMIT;
            end
            COMMIT: begin
                cfg_commit_done_o = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign lkp_fire = lkp_valid_i && lkp_ready_o;

    // ------------------------------------------------------------------
    // Shadow bank. The lock test uses the active lock, so a rule becomes
    // immutable only once its lock has been committed. A write in the
    // COMMIT cycle updates shadow after active has sampled it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NR_RULES; i++) begin
                shadow[i] <= rst_rule(i);
            end
        end else if (cfg_we_i) begin
            // Indices outside the table never compare equal, so they drop.
            for (int unsigned i = 0; i < NR_RULES; i++) begin
                if (cfg_idx_i == IDX_W'(i) && !active[i].lock) begin
                    case (pma_field_e'(cfg_sel_i))
                        FLD_BASE: shadow[i].base <= PMA_ADDR_W'(cfg_wdata_i);
                        FLD_LEN:  shadow[i].len  <= PMA_ADDR_W'(cfg_wdata_i);
                        FLD_ATTR: shadow[i].attr <= pma_attr_t'(cfg_wdata_i[2:0]);
                        FLD_LOCK: if (cfg_wdata_i[0]) shadow[i].lock <= 1'b1;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Active bank: whole-table copy of unlocked rules in the COMMIT cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NR_RULES; i++) begin
                active[i] <= rst_rule(i);
            end
        end else if (state_q == COMMIT) begin
            for (int unsigned i = 0; i < NR_RULES; i++) begin
                if (!active[i].lock) active[i] <= shadow[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-rule comparators and lowest-index-wins priority encoder
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NR_RULES; g++) begin : g_match
        pma_rule_match #(.ADDR_W(ADDR_W)) u_match (
            .addr  (lkp_addr_i),
            .base  (active[g].base[ADDR_W-1:0]),
            .len   (active[g].len[ADDR_W-1:0]),
            .match (match[g])
        );
    end

    always_comb begin
        win_hit  = 1'b0;
        win_idx  = '0;
        win_attr = DEFAULT_ATTR;
        // Scan from the top so the lowest matching index is written last.
        for (int i = NR_RULES - 1; i >= 0; i--) begin
            if (match[i]) begin
                win_hit  = 1'b1;
                win_idx  = IDX_W'(i);
                win_attr = ATTR_W'(active[i].attr);
            end
        end
    end

    // ------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_attr_q  <= DEFAULT_ATTR;
        end else begin
            rsp_valid_q <= lkp_fire;
            if (lkp_fire) begin
                rsp_hit_q  <= win_hit;
                rsp_idx_q  <= win_idx;
                rsp_attr_q <= win_attr;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_hit_o   = rsp_hit_q;
    assign rsp_idx_o   = rsp_idx_q;
    assign rsp_attr_o  = rsp_attr_q;

    // ------------------------------------------------------------------
    // Sticky multi-match flag
    // ------------------------------------------------------------------
`ifdef PMA_RULE_TABLE_MULTI_HIT_EN
    logic multi_hit_q;
    logic multi_now;

    // Clearing the lowest set bit leaves something only if two or more matched.
    assign multi_now = |(match & (match - NR_RULES'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            multi_hit_q <= 1'b0;
        end else if (state_q == COMMIT) begin
            multi_hit_q <= 1'b0;
        end else if (lkp_fire && multi_now) begin
            multi_hit_q <= 1'b1;
        end
    end

    assign multi_hit_o = multi_hit_q;
`else
    assign multi_hit_o = 1'b0;
`endif

endmodule

// File: tb/tb_pma_rule_table.sv
// Self-checking bench for pma_rule_table: directed scenarios plus randomized traffic
// compared against a rule-list reference model of the table.
// Runs with or without PMA_RULE_TABLE_MULTI_HIT_EN.
module tb_pma_rule_table;

    localparam int NR = 8;
    localparam logic [2:0] DEF_ATTR = 3'b010;
    localparam logic [NR*64-1:0] TB_RST_BASE = {448'h0, 64'h0000_0000_8000_0000};
    localparam logic [NR*64-1:0] TB_RST_LEN  = {448'h0, 64'h0000_0000_4000_0000};
    localparam logic [NR*3-1:0]  TB_RST_ATTR = {21'h0, 3'b111};

    logic        clk;
    logic        rst_ni;
    logic        lkp_valid;
    logic        lkp_ready;
    logic [63:0] lkp_addr;
    logic        rsp_valid;
    logic [2:0]  rsp_attr;
    logic        rsp_hit;
    logic [2:0]  rsp_idx;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [1:0]  cfg_sel;
    logic [63:0] cfg_wdata;
    logic        cfg_commit;
    logic        cfg_commit_done;
    logic        cfg_busy;
    logic        multi_hit;

    pma_rule_table #(
        .NR_RULES     (NR),
        .ADDR_W       (64),
        .ATTR_W       (3),
        .DEFAULT_ATTR (DEF_ATTR),
        .RST_BASE     (TB_RST_BASE),
        .RST_LEN      (TB_RST_LEN),
        .RST_ATTR     (TB_RST_ATTR)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .lkp_valid_i       (lkp_valid),
        .lkp_ready_o       (lkp_ready),
        .lkp_addr_i        (lkp_addr),
        .rsp_valid_o       (rsp_valid),
        .rsp_attr_o        (rsp_attr),
        .rsp_hit_o         (rsp_hit),
        .rsp_idx_o         (rsp_idx),
        .cfg_we_i          (cfg_we),
        .cfg_idx_i         (cfg_idx),
        .cfg_sel_i         (cfg_sel),
        .cfg_wdata_i       (cfg_wdata),
        .cfg_commit_i      (cfg_commit),
        .cfg_commit_done_o (cfg_commit_done),
        .cfg_busy_o        (cfg_busy),
        .multi_hit_o       (multi_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] sh_base [NR];
    logic [63:0] sh_len  [NR];
    logic [2:0]  sh_attr [NR];
    bit          sh_lock [NR];
    logic [63:0] ac_base [NR];
    logic [63:0] ac_len  [NR];
    logic [2:0]  ac_attr [NR];
    bit          ac_lock [NR];

    int          commit_left;   // busy cycles still to come after a commit request
    bit          exp_vld;
    logic [2:0]  exp_attr;
    bit          exp_hit;
    int          exp_idx;
    bit          exp_multi;
    bit          obs_ready;
    bit          obs_done;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            ac_base[i] = TB_RST_BASE[i*64 +: 64];
            ac_len[i]  = TB_RST_LEN[i*64 +: 64];
            ac_attr[i] = TB_RST_ATTR[i*3 +: 3];
            ac_lock[i] = 1'b0;
            sh_base[i] = ac_base[i];
            sh_len[i]  = ac_len[i];
            sh_attr[i] = ac_attr[i];
            sh_lock[i] = 1'b0;
        end
        commit_left = 0;
        exp_vld     = 1'b0;
        exp_attr    = DEF_ATTR;
        exp_hit     = 1'b0;
        exp_idx     = 0;
        exp_multi   = 1'b0;
    endtask

    function automatic void model_lookup(input logic [63:0] a, output logic [2:0] at,
                                         output bit h, output int ix, output int cnt);
        logic [63:0] off;
        at  = DEF_ATTR;
        h   = 1'b0;
        ix  = 0;
        cnt = 0;
        for (int i = 0; i < NR; i++) begin
            off = a - ac_base[i];
            if (ac_len[i] != 0 && a >= ac_base[i] && off < ac_len[i]) begin
                cnt++;
                if (!h) begin
                    h  = 1'b1;
                    ix = i;
                    at = ac_attr[i];
                end
            end
        end
    endfunction

    // One clock cycle: check outputs of the previous edge, drive inputs,
    // check the combinational handshake/status, advance the model.
    task automatic step(input bit lv, input logic [63:0] la, input bit we, input int widx,
                        input int sel, input logic [63:0] wd, input bit cm);
        bit          exp_ready;
        bit          hs;
        bit          wr_ok;
        logic [2:0]  at;
        bit          h;
        int          ix;
        int          cnt;

        check("rsp_valid", rsp_valid, exp_vld);
        if (exp_vld) begin
            check("rsp_attr", rsp_attr, exp_attr);
            check("rsp_hit", rsp_hit, exp_hit);
            check("rsp_idx", rsp_idx, exp_idx);
        end
        check("multi_hit", multi_hit, exp_multi);

        lkp_valid  = lv;
        lkp_addr   = la;
        cfg_we     = we;
        cfg_idx    = widx[2:0];
        cfg_sel    = sel[1:0];
        cfg_wdata  = wd;
        cfg_commit = cm;
        #1;

        exp_ready = (commit_left == 0) && !cm;
        check("lkp_ready", lkp_ready, exp_ready);
        check("cfg_busy", cfg_busy, commit_left != 0);
        check("commit_done", cfg_commit_done, commit_left == 1);
        obs_ready = lkp_ready;
        obs_done  = cfg_commit_done;

        hs = lv && exp_ready;
        exp_vld = hs;
        if (hs) begin
            model_lookup(la, at, h, ix, cnt);
            exp_attr = at;
            exp_hit  = h;
            exp_idx  = ix;
        end else begin
            cnt = 0;
        end
`ifdef PMA_RULE_TABLE_MULTI_HIT_EN
        if (commit_left == 1) exp_multi = 1'b0;
        else if (hs && cnt > 1) exp_multi = 1'b1;
`endif

        wr_ok = we && widx < NR && !ac_lock[widx];
        if (commit_left == 1) begin
            for (int i = 0; i < NR; i++) begin
                if (!ac_lock[i]) begin
                    ac_base[i] = sh_base[i];
                    ac_len[i]  = sh_len[i];
                    ac_attr[i] = sh_attr[i];
                    ac_lock[i] = sh_lock[i];
                end
            end
        end
        if (wr_ok) begin
            case (sel)
                0: sh_base[widx] = wd;
                1: sh_len[widx]  = wd;
                2: sh_attr[widx] = wd[2:0];
                default: if (wd[0]) sh_lock[widx] = 1'b1;
            endcase
        end
        if (commit_left > 0) commit_left--;
        else if (cm) commit_left = 2;

        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 64'h0, 0, 0, 0, 64'h0, 0);
    endtask

    task automatic lookup(input logic [63:0] a);
        step(1, a, 0, 0, 0, 64'h0, 0);
    endtask

    task automatic wr(input int idx, input int sel, input logic [63:0] d);
        step(0, 64'h0, 1, idx, sel, d, 0);
    endtask

    task automatic commit();
        step(0, 64'h0, 0, 0, 0, 64'h0, 1);
        idle();
        idle();
    endtask

    task automatic do_reset();
        rst_ni     = 1'b0;
        lkp_valid  = 1'b0;
        lkp_addr   = '0;
        cfg_we     = 1'b0;
        cfg_idx    = '0;
        cfg_sel    = '0;
        cfg_wdata  = '0;
        cfg_commit = 1'b0;
        #2;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_attr", rsp_attr, DEF_ATTR);
        check("rst_rsp_hit", rsp_hit, 1'b0);
        check("rst_rsp_idx", rsp_idx, 0);
        check("rst_busy", cfg_busy, 1'b0);
        check("rst_done", cfg_commit_done, 1'b0);
        check("rst_multi", multi_hit, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    int nlow;
    int ndone;

    initial begin
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset-programmed rule 0
        lookup(64'h8000_1000);
        check("rst_rule_attr", rsp_attr, 3'b111);
        check("rst_rule_hit", rsp_hit, 1'b1);
        lookup(64'h7FFF_FFFF);
        check("below_rule_attr", rsp_attr, DEF_ATTR);
        check("below_rule_hit", rsp_hit, 1'b0);
        lookup(64'hBFFF_FFFF);
        lookup(64'hC000_0000);
        idle();

        // Priority between overlapping rules 1 and 3
        wr(1, 0, 64'h1_0000); wr(1, 1, 64'h1000); wr(1, 2, 64'h1);
        wr(3, 0, 64'hF000);   wr(3, 1, 64'h2000); wr(3, 2, 64'h4);
        commit();
        lookup(64'h1_0000);
        check("prio_attr", rsp_attr, 3'b001);
        check("prio_idx", rsp_idx, 1);
        idle();
`ifdef PMA_RULE_TABLE_MULTI_HIT_EN
        check("multi_set", multi_hit, 1'b1);
        lookup(64'hF800);
        idle();
        check("multi_sticky", multi_hit, 1'b1);
        commit();
        check("multi_clr", multi_hit, 1'b0);
`else
        check("multi_off", multi_hit, 1'b0);
`endif

        // Top-of-address-space region
        wr(4, 0, 64'hFFFF_FFFF_FFFF_F000); wr(4, 1, 64'h1000); wr(4, 2, 64'h5);
        commit();
        lookup(64'hFFFF_FFFF_FFFF_FFFF);
        check("top_hit", rsp_hit, 1'b1);
        check("top_idx", rsp_idx, 4);
        lookup(64'hFFFF_FFFF_FFFF_EFFF);
        check("top_below_hit", rsp_hit, 1'b0);
        lookup(64'h0);
        check("top_wrap_hit", rsp_hit, 1'b0);
        idle();

        // Commit atomicity with a lookup in flight
        wr(2, 0, 64'h2000); wr(2, 1, 64'h100); wr(2, 2, 64'h1);
        lookup(64'h2010);
        check("pre_commit_attr", rsp_attr, DEF_ATTR);
        lookup(64'h2010);
        nlow  = 0;
        ndone = 0;
        step(0, 64'h0, 0, 0, 0, 64'h0, 1);
        nlow += !obs_ready; ndone += obs_done;
        for (int k = 0; k < 3; k++) begin
            step(1, 64'h2010, 0, 0, 0, 64'h0, 0);
            nlow += !obs_ready; ndone += obs_done;
        end
        check("commit_ready_low_cycles", nlow, 3);
        check("commit_done_pulses", ndone, 1);
        check("post_commit_attr", rsp_attr, 3'b001);
        check("post_commit_idx", rsp_idx, 2);
        idle();

        // Write landing in the COMMIT cycle is not committed
        step(0, 64'h0, 0, 0, 0, 64'h0, 1);
        idle();
        wr(5, 1, 64'h10);      // lands during COMMIT
        lookup(64'h0);
        check("late_write_hit", rsp_hit, 1'b0);
        commit();
        lookup(64'h8);
        check("late_write_next_commit", rsp_idx, 5);
        idle();

        // Lock
        wr(0, 3, 64'h1);
        commit();
        wr(0, 0, 64'h0);
        commit();
        lookup(64'h8000_1000);
        check("lock_attr", rsp_attr, 3'b111);
        check("lock_idx", rsp_idx, 0);
        idle();

        // Reset mid-commit aborts it and clears locks
        wr(6, 0, 64'h3000); wr(6, 1, 64'h100);
        step(0, 64'h0, 0, 0, 0, 64'h0, 1);
        idle();
        do_reset();
        lookup(64'h3000);
        check("abort_hit", rsp_hit, 1'b0);
        wr(0, 0, 64'h0); wr(0, 1, 64'h10);
        commit();
        lookup(64'h8);
        check("unlock_hit", rsp_hit, 1'b1);
        check("unlock_idx", rsp_idx, 0);
        idle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit          lv;
            bit          we;
            bit          cm;
            int          sel;
            logic [63:0] a;
            logic [63:0] d;
            lv  = ($urandom_range(0, 2) != 0);
            a   = (64'($urandom_range(0, 17)) << 12) | 64'($urandom_range(0, 4095));
            we  = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 3);
            case (sel)
                0: d = 64'($urandom_range(0, 15)) << 12;
                1: d = 64'($urandom_range(0, 3)) << 12;
                2: d = 64'($urandom_range(0, 7));
                default: d = 64'($urandom_range(0, 15) == 0);
            endcase
            cm  = ($urandom_range(0, 19) == 0);
            step(lv, a, we, $urandom_range(0, NR - 1), sel, d, cm);
        end
        idle();
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
